ffe_lane_serializer: RTL and testbench

- Downstream of the FFE: takes the 4-lane, 8-bit equalized word the FFE presents on its io_out_valid/io_out_bits_0..3 outputs.
- Buffers whole words in a small FIFO and streams them one symbol per cycle, lane 0 first, to the DAC-side interface through a valid/ready handshake.
- The FFE output has no backpressure, so a word that arrives while the buffer is full is dropped and reported with a sticky overflow flag.

---
 rtl/ffe_lane_serializer_if.sv | 31 +++
 rtl/ffe_lane_serializer.sv | 120 ++++++++++++
 tb/tb_ffe_lane_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ffe_lane_serializer_if.sv
// Word-in / symbol-out bus between the FFE output, the lane serializer and the DAC side.
// The FFE side has no ready: io_in_valid is a pure strobe.
interface ffe_lane_serializer_if #(
  parameter int WIDTH   = 8,
  parameter int LEVEL_W = 3
);
  logic               io_in_valid;
  logic [WIDTH-1:0]   io_in_bits_0;
  logic [WIDTH-1:0]   io_in_bits_1;
  logic [WIDTH-1:0]   io_in_bits_2;
  logic [WIDTH-1:0]   io_in_bits_3;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [WIDTH-1:0]   io_out_bits;
  logic               io_out_last;
  logic [LEVEL_W-1:0] io_level;
  logic               io_overflow;
  logic               io_clear_overflow;

  modport master (
    output io_in_valid, io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3,
    output io_out_ready, io_clear_overflow,
    input  io_out_valid, io_out_bits, io_out_last, io_level, io_overflow
  );

  modport slave (
    input  io_in_valid, io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3,
    input  io_out_ready, io_clear_overflow,
    output io_out_valid, io_out_bits, io_out_last, io_level, io_overflow
  );
endinterface

// File: rtl/ffe_lane_serializer.sv
// Buffers 4-lane FFE words in a small FIFO and streams them one symbol per cycle, lane 0 first.
// Words arriving with no room are dropped and flagged on a sticky overflow bit.
module ffe_lane_serializer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,   // fixed at 4 by the io_in_bits_0..3 port set
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ffe_lane_serializer_if.slave  bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int IDX_W   = $clog2(LANES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);

  typedef logic [LANES-1:0][WIDTH-1:0] word_t;

  word_t               mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  word_t               ser_word_q, ser_word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                loaded_q, loaded_d;
  logic                overflow_q, overflow_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_bits_q, out_bits_d;
  logic                out_last_q, out_last_d;

  word_t in_word;
  logic  fire, end_word, vacate, fifo_empty, fifo_full;
  logic  pop, bypass, push, drop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_word    = {bus.io_in_bits_3, bus.io_in_bits_2, bus.io_in_bits_1, bus.io_in_bits_0};
    fire       = loaded_q && bus.io_out_ready;
    end_word   = fire && (idx_q == LAST_IDX);
    vacate     = !loaded_q || end_word;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == FULL_LVL);

    // Serializer refill has priority over the FIFO: the head word goes first, the input only
    // bypasses when nothing is buffered ahead of it.
    pop    = vacate && !fifo_empty;
    bypass = vacate && fifo_empty && bus.io_in_valid;
    push   = bus.io_in_valid && !bypass && (!fifo_full || pop);
    drop   = bus.io_in_valid && !bypass && fifo_full && !pop;

    ser_word_d = ser_word_q;
    idx_d      = idx_q;
    loaded_d   = loaded_q;
    if (pop) begin
      ser_word_d = mem_q[rd_ptr_q];
      idx_d      = '0;
      loaded_d   = 1'b1;
    end else if (bypass) begin
      ser_word_d = in_word;
      idx_d      = '0;
      loaded_d   = 1'b1;
    end else if (end_word) begin
      idx_d    = '0;
      loaded_d = 1'b0;
    end else if (fire) begin
      idx_d = idx_q + 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = drop ? 1'b1 : (bus.io_clear_overflow ? 1'b0 : overflow_q);

    // Outputs are registered copies of the next serializer view.
    out_valid_d = loaded_d;
    out_bits_d  = ser_word_d[idx_d];
    out_last_d  = loaded_d && (idx_d == LAST_IDX);
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ser_word_q  <= '0;
      idx_q       <= '0;
      loaded_q    <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ser_word_q  <= ser_word_d;
      idx_q       <= idx_d;
      loaded_q    <= loaded_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and level define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

  assign bus.io_out_valid = out_valid_q;
  assign bus.io_out_bits  = out_bits_q;
  assign bus.io_out_last  = out_last_q;
  assign bus.io_level     = level_q;
  assign bus.io_overflow  = overflow_q;
endmodule

// File: tb/tb_ffe_lane_serializer.sv
// Directed bench for ffe_lane_serializer: a driver queues expected symbols, a monitor
// pops and compares each accepted symbol, and the main flow checks level/overflow/flags.
module tb_ffe_lane_serializer;
  typedef logic [3:0][7:0] word_t;
  typedef struct {
    logic [7:0] bits;
    logic       last;
  } sym_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests  = 0;
  int   failed = 0;
  sym_t exp_q [$];

  ffe_lane_serializer_if #(.WIDTH(8), .LEVEL_W(3)) bus ();

  ffe_lane_serializer #(.WIDTH(8), .LANES(4), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic word_t mk(input int k);
    word_t w;
    for (int l = 0; l < 4; l++) w[l] = 8'(k * 16 + l + 1);
    return w;
  endfunction

  task automatic expect_word(input word_t w);
    for (int l = 0; l < 4; l++) exp_q.push_back('{bits: w[l], last: (l == 3)});
  endtask

  task automatic send_word(input word_t w);
    bus.io_in_valid  = 1'b1;
    bus.io_in_bits_0 = w[0];
    bus.io_in_bits_1 = w[1];
    bus.io_in_bits_2 = w[2];
    bus.io_in_bits_3 = w[3];
    tick();
    bus.io_in_valid  = 1'b0;
  endtask

  // Monitor: a symbol is accepted at the next rising edge when valid && ready (and not in reset).
  initial begin
    sym_t e;
    forever begin
      @(negedge clock);
      if (reset && bus.io_out_valid && bus.io_out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL sb_unexpected: got symbol 0x%0h, expected no symbol at %0t",
                   bus.io_out_bits, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_bits", 32'(bus.io_out_bits), 32'(e.bits));
          check("sb_last", 32'(bus.io_out_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    word_t w, a, b;
    int    max_level;

    bus.io_in_valid       = 1'b0;
    bus.io_in_bits_0      = '0;
    bus.io_in_bits_1      = '0;
    bus.io_in_bits_2      = '0;
    bus.io_in_bits_3      = '0;
    bus.io_out_ready      = 1'b0;
    bus.io_clear_overflow = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(bus.io_out_valid), 0);
    check("rst_bits", 32'(bus.io_out_bits), 0);
    check("rst_last", 32'(bus.io_out_last), 0);
    check("rst_level", 32'(bus.io_level), 0);
    check("rst_overflow", 32'(bus.io_overflow), 0);
    reset = 1'b1;
    tick();

    // 1: single word, ready held high, one-cycle latency
    bus.io_out_ready = 1'b1;
    w = {8'd40, 8'd30, 8'd20, 8'd10};
    expect_word(w);
    send_word(w);
    check("t1_latency_valid", 32'(bus.io_out_valid), 1);
    check("t1_latency_bits", 32'(bus.io_out_bits), 10);
    for (int i = 0; i < 4; i++) begin
      check("t1_level", 32'(bus.io_level), 0);
      tick();
    end
    check("t1_idle_valid", 32'(bus.io_out_valid), 0);

    // 2: backpressure while symbol 20 is shown
    expect_word(w);
    send_word(w);
    tick();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", 32'(bus.io_out_valid), 1);
      check("t2_hold_bits", 32'(bus.io_out_bits), 20);
      check("t2_hold_last", 32'(bus.io_out_last), 0);
      tick();
    end
    bus.io_out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t2_idle_valid", 32'(bus.io_out_valid), 0);

    // 3: back-to-back words, no gap between them
    a = {8'h04, 8'h03, 8'h02, 8'h01};
    b = {8'h14, 8'h13, 8'h12, 8'h11};
    expect_word(a);
    expect_word(b);
    send_word(a);
    send_word(b);
    check("t3_level_after_b", 32'(bus.io_level), 1);
    max_level = 0;
    for (int i = 0; i < 7; i++) begin
      check("t3_no_gap", 32'(bus.io_out_valid), 1);
      if (int'(bus.io_level) > max_level) max_level = int'(bus.io_level);
      tick();
    end
    check("t3_level_peak", 32'(max_level), 1);
    check("t3_idle_valid", 32'(bus.io_out_valid), 0);

    // 4: fill with ready low, W5 is dropped
    bus.io_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) expect_word(mk(k));
      send_word(mk(k));
    end
    check("t4_level_full", 32'(bus.io_level), 4);
    check("t4_overflow", 32'(bus.io_overflow), 1);
    check("t4_head_bits", 32'(bus.io_out_bits), 32'(8'h01));
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t4_drained_valid", 32'(bus.io_out_valid), 0);
    check("t4_drained_level", 32'(bus.io_level), 0);

    // 5: clear without drop, then drop colliding with clear
    bus.io_clear_overflow = 1'b1;
    tick();
    bus.io_clear_overflow = 1'b0;
    check("t5_clear", 32'(bus.io_overflow), 0);
    bus.io_out_ready = 1'b0;
    for (int k = 8; k < 13; k++) begin
      expect_word(mk(k));
      send_word(mk(k));
    end
    check("t5_level_full", 32'(bus.io_level), 4);
    bus.io_clear_overflow = 1'b1;
    send_word(mk(13));
    bus.io_clear_overflow = 1'b0;
    check("t5_set_wins", 32'(bus.io_overflow), 1);
    check("t5_level_kept", 32'(bus.io_level), 4);
    bus.io_clear_overflow = 1'b1;
    tick();
    bus.io_clear_overflow = 1'b0;
    check("t5_later_clear", 32'(bus.io_overflow), 0);
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t5_drained_valid", 32'(bus.io_out_valid), 0);

    // 6: reset mid-stream discards everything
    bus.io_out_ready = 1'b0;
    w = mk(5);
    exp_q.push_back('{bits: w[0], last: 1'b0});
    send_word(w);
    send_word(mk(6));
    send_word(mk(7));
    bus.io_out_ready = 1'b1;
    tick();
    check("t6_pre_bits", 32'(bus.io_out_bits), 32'(w[1]));
    check("t6_pre_level", 32'(bus.io_level), 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_rst_valid", 32'(bus.io_out_valid), 0);
    check("t6_rst_level", 32'(bus.io_level), 0);
    check("t6_rst_overflow", 32'(bus.io_overflow), 0);
    check("t6_sb_empty", 32'(exp_q.size()), 0);
    w = mk(9);
    expect_word(w);
    send_word(w);
    check("t6_restart_valid", 32'(bus.io_out_valid), 1);
    check("t6_restart_bits", 32'(bus.io_out_bits), 32'(w[0]));
    for (int i = 0; i < 4; i++) tick();
    check("t6_idle_valid", 32'(bus.io_out_valid), 0);

    tick();
    check("final_sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
